mem_read_arbiter: RTL and testbench

Shares the single AXI4 read channel (AR + R) to external memory between N cache controllers. Requester 0 is the instruction cache controller's miss/refill port and requester 1 the data cache controller's read port. It accepts one burst request at a time by round-robin and forwards it downstream. It then routes the returned beats back to the granted requester and holds the channel until the last beat. Only one transaction is outstanding, so no AXI IDs are used.

---
 rtl/mem_read_arbiter_pkg.sv | 31 +++
 rtl/mem_read_arbiter_rr_arbiter.sv | 39 +++
 rtl/mem_read_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// ============================================================================
// mem_read_arbiter_pkg : shared AXI read-channel types and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_read_arbiter_pkg;

  localparam int AXI_LEN_BITS = 8;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Width of a requester index; a single bit even for the degenerate N=1 case.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at/after pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  always_comb begin : p_pick
    int               v_sum;
    logic [PTR_W-1:0] v_idx;
    logic             v_found;
    o_grant = '0;
    v_found = 1'b0;
    v_sum   = 0;
    v_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      v_sum = int'(i_ptr) + off;
      if (v_sum >= N_REQ) begin
        v_sum = v_sum - N_REQ;
      end
      v_idx = v_sum[PTR_W-1:0];
      if (!v_found && i_req[v_idx]) begin
        o_grant[v_idx] = 1'b1;
        v_found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_read_arbiter.sv
// ============================================================================
// mem_read_arbiter : shares one AXI4 read channel between N cache requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int LEN_BITS  = AXI_LEN_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N_REQ-1:0]              i_ar_valid,
  input  logic [N_REQ*ADDR_SIZE-1:0]    i_ar_addr,
  input  logic [N_REQ*LEN_BITS-1:0]     i_ar_len,
  output logic [N_REQ-1:0]              o_ar_ready,
  output logic [N_REQ-1:0]              o_r_valid,
  output logic [DATA_SIZE-1:0]          o_r_data,
  output logic                          o_r_last,
  input  logic [N_REQ-1:0]              i_r_ready,
  output logic                          o_m_ar_valid,
  output logic [ADDR_SIZE-1:0]          o_m_ar_addr,
  output logic [LEN_BITS-1:0]           o_m_ar_len,
  input  logic                          i_m_ar_ready,
  input  logic                          i_m_r_valid,
  input  logic [DATA_SIZE-1:0]          i_m_r_data,
  input  logic                          i_m_r_last,
  input  logic [1:0]                    i_m_r_resp,
  output logic                          o_m_r_ready,
  output logic                          o_len_err
);

  localparam int PTR_W = ptr_width(N_REQ);

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_gnt_idx;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [N_REQ-1:0]     w_gnt;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [LEN_BITS-1:0]  r_len;
  logic [LEN_BITS-1:0]  r_cnt;
  logic                 w_any_req;
  logic                 w_r_hs;
  logic                 w_unused_resp;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (i_ar_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx = PTR_W'(i);
      end
    end
  end

  assign w_any_req = |i_ar_valid;
  assign w_r_hs    = (r_state == ST_DATA) && i_m_r_valid && i_r_ready[r_gnt_idx];

  // Response code is deliberately ignored; error handling lives in the caches.
  assign w_unused_resp = ^i_m_r_resp;

  always_comb begin
    w_next_state = r_state;
    o_ar_ready   = '0;
    o_r_valid    = '0;
    o_r_data     = '0;
    o_r_last     = 1'b0;
    o_m_ar_valid = 1'b0;
    o_m_ar_addr  = '0;
    o_m_ar_len   = '0;
    o_m_r_ready  = 1'b0;
    o_len_err    = 1'b0;
    if (i_reset) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            o_ar_ready   = w_gnt;
            w_next_state = ST_ADDR;
          end
        end
        ST_ADDR: begin
          o_m_ar_valid = 1'b1;
          o_m_ar_addr  = r_addr;
          o_m_ar_len   = r_len;
          if (i_m_ar_ready) begin
            w_next_state = ST_DATA;
          end
        end
        ST_DATA: begin
          o_r_valid[r_gnt_idx] = i_m_r_valid;
          o_m_r_ready          = i_r_ready[r_gnt_idx];
          o_r_data             = i_m_r_data;
          o_r_last             = i_m_r_last;
          if (w_r_hs) begin
            // Early last, or a non-last beat where the last one was due.
            o_len_err = i_m_r_last ? (r_cnt != r_len) : (r_cnt == r_len);
            if (i_m_r_last) begin
              w_next_state = ST_IDLE;
            end
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt_idx <= w_gnt_idx;
            r_addr    <= i_ar_addr[int'(w_gnt_idx)*ADDR_SIZE +: ADDR_SIZE];
            r_len     <= i_ar_len[int'(w_gnt_idx)*LEN_BITS +: LEN_BITS];
          end
        end
        ST_ADDR: begin
          if (i_m_ar_ready) begin
            r_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (i_m_r_last) begin
              if (r_gnt_idx == PTR_W'(N_REQ - 1)) begin
                r_rr_ptr <= '0;
              end else begin
                r_rr_ptr <= r_gnt_idx + 1'b1;
              end
            end
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
// ============================================================================
// tb_mem_read_arbiter : directed + randomized bench for mem_read_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_read_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [N-1:0]      i_ar_valid;
  logic [N*AW-1:0]   i_ar_addr;
  logic [N*LW-1:0]   i_ar_len;
  logic [N-1:0]      o_ar_ready;
  logic [N-1:0]      o_r_valid;
  logic [DW-1:0]     o_r_data;
  logic              o_r_last;
  logic [N-1:0]      i_r_ready;
  logic              o_m_ar_valid;
  logic [AW-1:0]     o_m_ar_addr;
  logic [LW-1:0]     o_m_ar_len;
  logic              i_m_ar_ready;
  logic              i_m_r_valid;
  logic [DW-1:0]     i_m_r_data;
  logic              i_m_r_last;
  logic [1:0]        i_m_r_resp;
  logic              o_m_r_ready;
  logic              o_len_err;

  always #5 clk = ~clk;

  mem_read_arbiter #(
    .N_REQ     (N),
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .LEN_BITS  (LW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_ar_valid   (i_ar_valid),
    .i_ar_addr    (i_ar_addr),
    .i_ar_len     (i_ar_len),
    .o_ar_ready   (o_ar_ready),
    .o_r_valid    (o_r_valid),
    .o_r_data     (o_r_data),
    .o_r_last     (o_r_last),
    .i_r_ready    (i_r_ready),
    .o_m_ar_valid (o_m_ar_valid),
    .o_m_ar_addr  (o_m_ar_addr),
    .o_m_ar_len   (o_m_ar_len),
    .i_m_ar_ready (i_m_ar_ready),
    .i_m_r_valid  (i_m_r_valid),
    .i_m_r_data   (i_m_r_data),
    .i_m_r_last   (i_m_r_last),
    .i_m_r_resp   (i_m_r_resp),
    .o_m_r_ready  (o_m_r_ready),
    .o_len_err    (o_len_err)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          m_ptr;
  logic [N-1:0] pend;
  logic [AW-1:0] q_addr [N];
  logic [LW-1:0] q_len  [N];
  bit          cont_mode;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] payload(input logic [AW-1:0] a, input int b);
    return a + (DW'(b) << 2);
  endfunction

  function automatic logic outs_any();
    return |{o_ar_ready, o_r_valid, o_r_data, o_r_last, o_m_ar_valid,
             o_m_ar_addr, o_m_ar_len, o_m_r_ready, o_len_err};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    i_ar_valid = pend;
    for (int k = 0; k < N; k++) begin
      i_ar_addr[k*AW +: AW] = q_addr[k];
      i_ar_len[k*LW +: LW]  = q_len[k];
    end
  endtask

  task automatic new_req(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
    pend[k]   = 1'b1;
    q_addr[k] = a;
    q_len[k]  = l;
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    pend         = '0;
    drive_req();
    i_m_r_valid  = 1'b1;
    i_r_ready    = '1;
    i_m_ar_ready = 1'b1;
    #1;
    check("rst_outs_during", outs_any(), 0);
    next_cyc();
    i_reset      = 1'b0;
    i_m_r_valid  = 1'b0;
    i_r_ready    = '0;
    i_m_ar_ready = 1'b0;
    #1;
    check("rst_outs_after", outs_any(), 0);
    m_ptr = 0;
  endtask

  // One complete transaction; mode 0 = no stalls, 1 = ready toggles, 2 = random.
  task automatic burst(input int ar_delay, input int last_off, input int mode, input int abort_after);
    int            g, len, last_beat, acc, cycles, b;
    logic [N-1:0]  ev;
    logic [AW-1:0] a;
    bit            mv, rr, is_last, hs, done;
    g = pick(pend, m_ptr);
    if (g < 0) begin
      $display("FAIL burst_no_pending observed=0 expected=1");
      $fatal(1, "bench called burst with nothing pending");
    end
    a   = q_addr[g];
    len = int'(q_len[g]);
    drive_req();
    #1;
    check("ar_ready", o_ar_ready, 64'(1 << g));
    check("ar_valid_idle", o_m_ar_valid, 0);
    next_cyc();
    if (cont_mode) q_addr[g] = q_addr[g] + 32'h100;
    else           pend[g]   = 1'b0;
    drive_req();
    for (int d = 0; d <= ar_delay; d++) begin
      i_m_ar_ready = (d == ar_delay);
      #1;
      check("m_ar_valid", o_m_ar_valid, 1);
      check("m_ar_addr", o_m_ar_addr, a);
      check("m_ar_len", o_m_ar_len, 64'(len));
      check("addr_quiet", {o_ar_ready, o_r_valid}, 0);
      next_cyc();
    end
    i_m_ar_ready = 1'b0;
    last_beat = len + last_off;
    if (last_beat < 0) last_beat = 0;
    b = 0; acc = 0; cycles = 0; done = 1'b0;
    while (!done) begin
      if (cycles >= 4000) begin
        check("data_timeout", 64'(cycles), 0);
        break;
      end
      if (abort_after >= 0 && acc == abort_after) begin
        do_reset();
        return;
      end
      case (mode)
        0:       begin mv = 1'b1; rr = 1'b1; end
        1:       begin mv = 1'b1; rr = (cycles % 2 == 0); end
        default: begin mv = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 2) != 0); end
      endcase
      for (int k = 0; k < N; k++) begin
        i_r_ready[k] = (k == g) ? rr : 1'($urandom_range(0, 1));
      end
      is_last     = (b == last_beat);
      i_m_r_valid = mv;
      i_m_r_data  = payload(a, b);
      i_m_r_last  = is_last;
      i_m_r_resp  = 2'($urandom_range(0, 3));
      #1;
      hs = mv && rr;
      ev = '0;
      ev[g] = mv;
      check("r_valid", o_r_valid, ev);
      check("m_r_ready", o_m_r_ready, rr);
      if (mv) begin
        check("r_data", o_r_data, payload(a, b));
        check("r_last", o_r_last, is_last);
      end
      check("len_err", o_len_err,
            hs && ((is_last && (b % 256) != len) || (!is_last && (b % 256) == len)));
      check("data_ar_quiet", {o_ar_ready, o_m_ar_valid}, 0);
      if (hs) begin
        acc++;
        b++;
        if (is_last) done = 1'b1;
      end
      next_cyc();
      cycles++;
    end
    i_m_r_valid = 1'b0;
    i_m_r_last  = 1'b0;
    i_r_ready   = '0;
    check("beats", 64'(acc), 64'(last_beat + 1));
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    i_reset      = 1'b1;
    i_ar_valid   = '0;
    i_ar_addr    = '0;
    i_ar_len     = '0;
    i_r_ready    = '0;
    i_m_ar_ready = 1'b0;
    i_m_r_valid  = 1'b0;
    i_m_r_data   = '0;
    i_m_r_last   = 1'b0;
    i_m_r_resp   = '0;
    pend         = '0;
    m_ptr        = 0;
    cont_mode    = 1'b0;
    for (int k = 0; k < N; k++) begin
      q_addr[k] = '0;
      q_len[k]  = '0;
    end
    next_cyc();
    next_cyc();
    check("reset_outs", outs_any(), 0);
    i_reset = 1'b0;
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      check("idle_quiet", outs_any(), 0);
      next_cyc();
    end

    // Contention right after reset: both stay requesting; grants alternate 0,1,0,1.
    cont_mode = 1'b1;
    new_req(0, 32'h0000_2000, 8'd2);
    new_req(1, 32'h0000_3000, 8'd1);
    burst(0, 0, 0, -1);
    burst(1, 0, 0, -1);
    cont_mode = 1'b0;
    burst(0, 0, 0, -1);
    burst(2, 0, 0, -1);

    new_req(0, 32'h0000_1000, 8'd3);
    burst(0, 0, 0, -1);

    new_req(1, 32'h0000_4000, 8'd7);
    burst(3, 0, 1, -1);

    new_req(0, 32'h0000_5000, 8'd3);
    burst(0, -1, 0, -1);
    new_req(1, 32'h0000_5800, 8'd2);
    burst(1, 1, 0, -1);

    new_req(0, 32'h0000_6000, 8'd255);
    burst(0, 0, 0, -1);

    // Pointer is at 1 here; the reset must bring it back to 0.
    new_req(1, 32'h0000_7000, 8'd3);
    burst(0, 0, 0, 2);
    new_req(0, 32'h0000_8000, 8'd1);
    new_req(1, 32'h0000_9000, 8'd2);
    burst(0, 0, 0, -1);
    burst(0, 0, 0, -1);

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          new_req(k, {$urandom_range(0, 32'hFFFF), 4'h0}, 8'($urandom_range(0, 7)));
        end
      end
      if (pend == '0) begin
        new_req($urandom_range(0, N - 1), {$urandom_range(0, 32'hFFFF), 4'h0},
                8'($urandom_range(0, 7)));
      end
      burst($urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 1 : -1) : 0,
            2, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
